// File: rtl/mem_arbiter.sv
// Shares one word-granular memory port between icache and dcache with a one-cycle grant,
// in-order read-return routing, read throttling and burst fairness. Macro: ARB_ROUND_ROBIN_EN.
module mem_arbiter #(
  parameter int MAX_OUTSTANDING = 4,
  parameter int BURST_LEN       = 4
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_ic_ren,
  input  logic [31:0] i_ic_addr,
  output logic        o_ic_ready,
  output logic [31:0] o_ic_rdata,
  output logic        o_ic_valid,
  input  logic        i_dc_ren,
  input  logic        i_dc_wen,
  input  logic [31:0] i_dc_addr,
  input  logic [31:0] i_dc_wdata,
  output logic        o_dc_ready,
  output logic [31:0] o_dc_rdata,
  output logic        o_dc_valid,
  input  logic        i_mem_ready,
  output logic [31:0] o_mem_addr,
  output logic        o_mem_ren,
  output logic        o_mem_wen,
  output logic [31:0] o_mem_wdata,
  input  logic [31:0] i_mem_rdata,
  input  logic        i_mem_valid,
  output logic [1:0]  o_owner,
  output logic        o_protocol_err
);
  localparam int CW = $clog2(MAX_OUTSTANDING) + 1;
  localparam int BW = $clog2(BURST_LEN + 1);
  localparam logic [CW-1:0] OUT_MAX   = CW'(MAX_OUTSTANDING);
  localparam logic [BW-1:0] BURST_MAX = BW'(BURST_LEN);

  typedef enum logic [1:0] {IDLE = 2'b00, OWN_I = 2'b01, OWN_D = 2'b10} state_t;

  state_t        state, state_nxt;
  logic          last_dc, last_dc_nxt;
  logic [CW-1:0] outstanding, outstanding_nxt;
  logic [BW-1:0] burst;
  logic          protocol_err;
  logic [31:0]   ic_rdata_q, dc_rdata_q;

  logic          ic_req, dc_req, dc_wins;
  logic          own_ren, own_wen, other_req;
  logic          rd_full, burst_full, yield_now, own_ready;
  logic          mem_ren, mem_wen, rd_acc, any_acc, beat_ok;
  logic          ic_valid, dc_valid;
  logic [31:0]   mem_addr, mem_wdata;

  assign ic_req = i_ic_ren;
  assign dc_req = i_dc_ren | i_dc_wen;

`ifdef ARB_ROUND_ROBIN_EN
  assign dc_wins = dc_req & (~ic_req | ~last_dc);
`else
  assign dc_wins = dc_req;
`endif

  always_comb begin
    own_ren   = 1'b0;
    own_wen   = 1'b0;
    other_req = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state)
      OWN_I: begin
        own_ren   = i_ic_ren;
        other_req = dc_req;
        mem_addr  = i_ic_addr;
      end
      OWN_D: begin
        own_ren   = i_dc_ren;
        own_wen   = i_dc_wen;
        other_req = ic_req;
        mem_addr  = i_dc_addr;
        mem_wdata = i_dc_wdata;
      end
      default: ;
    endcase
  end

  // A saturated burst with a waiting rival stops new accepts so the owner can drain and yield.
  assign rd_full    = (outstanding == OUT_MAX);
  assign burst_full = (burst == BURST_MAX);
  assign yield_now  = burst_full & other_req;
  assign mem_ren    = own_ren & ~rd_full & ~yield_now;
  assign mem_wen    = own_wen & ~yield_now;
  assign own_ready  = (state != IDLE) & i_mem_ready & ~yield_now & ~(own_ren & rd_full);
  assign rd_acc     = mem_ren & i_mem_ready;
  assign any_acc    = (mem_ren | mem_wen) & i_mem_ready;
  assign beat_ok    = i_mem_valid & (outstanding != '0);
  assign ic_valid   = beat_ok & (state == OWN_I);
  assign dc_valid   = beat_ok & (state == OWN_D);

  always_comb begin
    outstanding_nxt = outstanding;
    if (rd_acc && !beat_ok) begin
      outstanding_nxt = outstanding + CW'(1);
    end else if (!rd_acc && beat_ok) begin
      outstanding_nxt = outstanding - CW'(1);
    end
  end

  always_comb begin
    state_nxt   = state;
    last_dc_nxt = last_dc;
    case (state)
      IDLE: begin
        if (dc_wins) begin
          state_nxt   = OWN_D;
          last_dc_nxt = 1'b1;
        end else if (ic_req) begin
          state_nxt   = OWN_I;
          last_dc_nxt = 1'b0;
        end
      end
      OWN_I, OWN_D: begin
        if (outstanding_nxt == '0 && (!(own_ren || own_wen) || yield_now)) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state        <= IDLE;
      last_dc      <= 1'b0;
      outstanding  <= '0;
      burst        <= '0;
      protocol_err <= 1'b0;
      ic_rdata_q   <= '0;
      dc_rdata_q   <= '0;
    end else begin
      state       <= state_nxt;
      last_dc     <= last_dc_nxt;
      outstanding <= outstanding_nxt;
      if (state == IDLE) begin
        burst <= '0;
      end else if (any_acc && !burst_full) begin
        burst <= burst + BW'(1);
      end
      if (i_mem_valid && !beat_ok) begin
        protocol_err <= 1'b1;
      end
      if (ic_valid) begin
        ic_rdata_q <= i_mem_rdata;
      end
      if (dc_valid) begin
        dc_rdata_q <= i_mem_rdata;
      end
    end
  end

  assign o_owner        = state;
  assign o_mem_addr     = mem_addr;
  assign o_mem_wdata    = mem_wdata;
  assign o_mem_ren      = mem_ren;
  assign o_mem_wen      = mem_wen;
  assign o_ic_ready     = (state == OWN_I) & own_ready;
  assign o_dc_ready     = (state == OWN_D) & own_ready;
  assign o_ic_valid     = ic_valid;
  assign o_dc_valid     = dc_valid;
  assign o_ic_rdata     = ic_valid ? i_mem_rdata : ic_rdata_q;
  assign o_dc_rdata     = dc_valid ? i_mem_rdata : dc_rdata_q;
  assign o_protocol_err = protocol_err;

  a_last_owner: assert property (@(posedge i_clk) disable iff (i_rst)
    (state != IDLE) |-> (last_dc == (state == OWN_D)));
  a_out_bound: assert property (@(posedge i_clk) disable iff (i_rst)
    outstanding <= OUT_MAX);

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed table, corner-case sequences and random traffic
// compared every cycle against a queue-based reference model.
module tb_mem_arbiter;
  localparam int MAXO = 4;
  localparam int BL   = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        ic_ren, dc_ren, dc_wen, mem_ready, mem_valid;
  logic [31:0] ic_addr, dc_addr, dc_wdata, mem_rdata;
  logic        ic_ready, ic_valid, dc_ready, dc_valid, mem_ren, mem_wen, protocol_err;
  logic [31:0] ic_rdata, dc_rdata, mem_addr, mem_wdata;
  logic [1:0]  owner;

  always #5 clk = ~clk;

  mem_arbiter #(.MAX_OUTSTANDING(MAXO), .BURST_LEN(BL)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_ic_ren(ic_ren), .i_ic_addr(ic_addr), .o_ic_ready(ic_ready),
    .o_ic_rdata(ic_rdata), .o_ic_valid(ic_valid),
    .i_dc_ren(dc_ren), .i_dc_wen(dc_wen), .i_dc_addr(dc_addr), .i_dc_wdata(dc_wdata),
    .o_dc_ready(dc_ready), .o_dc_rdata(dc_rdata), .o_dc_valid(dc_valid),
    .i_mem_ready(mem_ready), .o_mem_addr(mem_addr), .o_mem_ren(mem_ren),
    .o_mem_wen(mem_wen), .o_mem_wdata(mem_wdata), .i_mem_rdata(mem_rdata),
    .i_mem_valid(mem_valid), .o_owner(owner), .o_protocol_err(protocol_err)
  );

  typedef struct packed {
    logic [1:0]  owner;
    logic        mem_ren, mem_wen;
    logic [31:0] mem_addr, mem_wdata;
    logic        ic_ready, ic_valid;
    logic [31:0] ic_rdata;
    logic        dc_ready, dc_valid;
    logic [31:0] dc_rdata;
    logic        err;
  } obs_t;
  localparam int OW = $bits(obs_t);

  typedef struct {
    logic        ic_ren;
    logic [31:0] ic_addr;
    logic        dc_ren, dc_wen;
    logic [31:0] dc_addr, dc_wdata;
    logic        mem_ready, mem_valid;
    logic [31:0] mem_rdata;
    obs_t        exp;
  } vec_t;

  int n_vec = 0;
  int n_bad = 0;
  int cyc = 0;
  int beat = 0;
  int resp_due[$];

  // Reference model: owner id 0 none, 1 icache, 2 dcache; each outstanding read is a queued issuer id.
  int          m_owner, m_last, m_burst;
  int          m_q[$];
  bit          m_err;
  logic [31:0] m_ic_rd, m_dc_rd;
  obs_t        exp_o;
  bit          e_rd_acc, e_any_acc, e_own_req, e_yield;

  function automatic obs_t dut_obs();
    return '{owner, mem_ren, mem_wen, mem_addr, mem_wdata, ic_ready, ic_valid, ic_rdata,
             dc_ready, dc_valid, dc_rdata, protocol_err};
  endfunction

  function automatic obs_t ob(input logic [1:0] ow, input logic mr, input logic mw,
                              input logic [31:0] ma, input logic [31:0] md,
                              input logic ir, input logic iv, input logic [31:0] id,
                              input logic dr, input logic dv, input logic [31:0] dd,
                              input logic er);
    return '{ow, mr, mw, ma, md, ir, iv, id, dr, dv, dd, er};
  endfunction

  task automatic check(input string name, input logic [OW-1:0] got, input logic [OW-1:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s (cycle %0d): got %0h, required %0h", name, cyc, got, want);
    end
  endtask

  task automatic model_eval();
    bit own_r, own_w, oth, full, rdy;
    own_r = (m_owner == 1) ? ic_ren : (m_owner == 2) ? dc_ren : 1'b0;
    own_w = (m_owner == 2) ? dc_wen : 1'b0;
    oth   = (m_owner == 1) ? (dc_ren | dc_wen) : (m_owner == 2) ? ic_ren : 1'b0;
    full  = (m_q.size() >= MAXO);
    e_yield   = (m_owner != 0) && (m_burst >= BL) && oth;
    e_own_req = own_r || own_w;
    exp_o = '0;
    exp_o.owner = 2'(m_owner);
    exp_o.err = m_err;
    exp_o.ic_rdata = m_ic_rd;
    exp_o.dc_rdata = m_dc_rd;
    if (m_owner != 0) begin
      exp_o.mem_ren   = own_r && !full && !e_yield;
      exp_o.mem_wen   = own_w && !e_yield;
      exp_o.mem_addr  = (m_owner == 1) ? ic_addr : dc_addr;
      exp_o.mem_wdata = (m_owner == 2) ? dc_wdata : 32'h0;
      rdy = mem_ready && !e_yield && !(own_r && full);
      if (m_owner == 1) exp_o.ic_ready = rdy;
      else exp_o.dc_ready = rdy;
    end
    e_rd_acc  = exp_o.mem_ren && mem_ready;
    e_any_acc = (exp_o.mem_ren || exp_o.mem_wen) && mem_ready;
    if (mem_valid && m_q.size() > 0) begin
      if (m_q[0] == 1) begin
        exp_o.ic_valid = 1'b1;
        exp_o.ic_rdata = mem_rdata;
      end else begin
        exp_o.dc_valid = 1'b1;
        exp_o.dc_rdata = mem_rdata;
      end
    end
  endtask

  task automatic model_update();
    int pick;
    if (rst) begin
      m_owner = 0; m_last = 1; m_burst = 0; m_err = 1'b0;
      m_q.delete();
      m_ic_rd = '0; m_dc_rd = '0;
    end else begin
      if (mem_valid) begin
        if (m_q.size() == 0) m_err = 1'b1;
        else begin
          if (m_q[0] == 1) m_ic_rd = mem_rdata;
          else m_dc_rd = mem_rdata;
          void'(m_q.pop_front());
        end
      end
      if (e_rd_acc) m_q.push_back(m_owner);
      if (e_any_acc && m_burst < BL) m_burst++;
      if (m_owner == 0) begin
        pick = 0;
        if (ic_ren && (dc_ren || dc_wen)) begin
`ifdef ARB_ROUND_ROBIN_EN
          pick = (m_last == 1) ? 2 : 1;
`else
          pick = 2;
`endif
        end else if (ic_ren) pick = 1;
        else if (dc_ren || dc_wen) pick = 2;
        if (pick != 0) begin
          m_owner = pick; m_last = pick; m_burst = 0;
        end
      end else if (m_q.size() == 0 && (!e_own_req || e_yield)) begin
        m_owner = 0;
      end
    end
  endtask

  task automatic sample(input string name);
    @(negedge clk);
    model_eval();
    check(name, dut_obs(), exp_o);
  endtask

  task automatic advance();
    @(posedge clk);
    if (!rst && e_rd_acc) resp_due.push_back(cyc + 2);
    model_update();
    cyc++;
    #1;
  endtask

  task automatic clear_inputs();
    ic_ren = 0; ic_addr = '0; dc_ren = 0; dc_wen = 0; dc_addr = '0; dc_wdata = '0;
    mem_ready = 0; mem_valid = 0; mem_rdata = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    resp_due.delete();
    advance();
    rst = 1'b0;
  endtask

  // Memory returns each accepted read two cycles later, data A0000000 + beat index.
  task automatic drive_resp();
    mem_valid = 1'b0;
    if (resp_due.size() > 0 && resp_due[0] <= cyc) begin
      void'(resp_due.pop_front());
      mem_valid = 1'b1;
      mem_rdata = 32'hA000_0000 + 32'(beat);
      beat++;
    end
  endtask

  vec_t tbl[13];
  int   pulses, acc, r;
  logic [1:0] ow[16];

  initial begin
    clear_inputs();
    rst = 1'b1;
    do_reset();

    tbl[0]  = '{0, 32'h0,   0, 0, 32'h0,   32'h0,        1, 0, 32'h0,
                ob(0, 0, 0, 32'h0,   32'h0,        0, 0, 32'h0, 0, 0, 32'h0, 0)};
    tbl[1]  = '{1, 32'h300, 0, 1, 32'h200, 32'hDEADBEEF, 1, 0, 32'h0,
                ob(0, 0, 0, 32'h0,   32'h0,        0, 0, 32'h0, 0, 0, 32'h0, 0)};
    tbl[2]  = '{1, 32'h300, 0, 1, 32'h200, 32'hDEADBEEF, 1, 0, 32'h0,
                ob(2, 0, 1, 32'h200, 32'hDEADBEEF, 0, 0, 32'h0, 1, 0, 32'h0, 0)};
    tbl[3]  = '{1, 32'h300, 0, 0, 32'h200, 32'hDEADBEEF, 1, 0, 32'h0,
                ob(2, 0, 0, 32'h200, 32'hDEADBEEF, 0, 0, 32'h0, 1, 0, 32'h0, 0)};
    tbl[4]  = '{1, 32'h300, 0, 0, 32'h0,   32'h0,        1, 0, 32'h0,
                ob(0, 0, 0, 32'h0,   32'h0,        0, 0, 32'h0, 0, 0, 32'h0, 0)};
    tbl[5]  = '{1, 32'h300, 0, 0, 32'h0,   32'h0,        0, 0, 32'h0,
                ob(1, 1, 0, 32'h300, 32'h0,        0, 0, 32'h0, 0, 0, 32'h0, 0)};
    tbl[6]  = '{0, 32'h300, 0, 0, 32'h0,   32'h0,        1, 0, 32'h0,
                ob(1, 0, 0, 32'h300, 32'h0,        1, 0, 32'h0, 0, 0, 32'h0, 0)};
    tbl[7]  = '{0, 32'h0,   0, 0, 32'h0,   32'h0,        0, 1, 32'h12345678,
                ob(0, 0, 0, 32'h0,   32'h0,        0, 0, 32'h0, 0, 0, 32'h0, 0)};
    tbl[8]  = '{0, 32'h0,   0, 0, 32'h0,   32'h0,        0, 0, 32'h0,
                ob(0, 0, 0, 32'h0,   32'h0,        0, 0, 32'h0, 0, 0, 32'h0, 1)};
    tbl[9]  = '{0, 32'h0,   1, 0, 32'h400, 32'h0,        1, 0, 32'h0,
                ob(0, 0, 0, 32'h0,   32'h0,        0, 0, 32'h0, 0, 0, 32'h0, 1)};
    tbl[10] = '{0, 32'h0,   1, 0, 32'h400, 32'h0,        1, 0, 32'h0,
                ob(2, 1, 0, 32'h400, 32'h0,        0, 0, 32'h0, 1, 0, 32'h0, 1)};
    tbl[11] = '{0, 32'h0,   0, 0, 32'h400, 32'h0,        1, 1, 32'hCAFE0001,
                ob(2, 0, 0, 32'h400, 32'h0,        0, 0, 32'h0, 1, 1, 32'hCAFE0001, 1)};
    tbl[12] = '{0, 32'h0,   0, 0, 32'h0,   32'h0,        0, 0, 32'h0,
                ob(0, 0, 0, 32'h0,   32'h0,        0, 0, 32'h0, 0, 0, 32'hCAFE0001, 1)};

    for (int i = 0; i < 13; i++) begin
      ic_ren = tbl[i].ic_ren; ic_addr = tbl[i].ic_addr;
      dc_ren = tbl[i].dc_ren; dc_wen = tbl[i].dc_wen;
      dc_addr = tbl[i].dc_addr; dc_wdata = tbl[i].dc_wdata;
      mem_ready = tbl[i].mem_ready; mem_valid = tbl[i].mem_valid; mem_rdata = tbl[i].mem_rdata;
      @(negedge clk);
      model_eval();
      check($sformatf("tbl%0d", i), dut_obs(), tbl[i].exp);
      advance();
    end

    // Second simultaneous request: last owner was dcache; error flag must still be set.
    clear_inputs();
    ic_ren = 1; ic_addr = 32'h310; dc_wen = 1; dc_addr = 32'h240; dc_wdata = 32'h55; mem_ready = 1;
    sample("tie2_idle");
    advance();
    sample("tie2_grant");
`ifdef ARB_ROUND_ROBIN_EN
    check("tie2_owner", OW'(owner), OW'(1));
`else
    check("tie2_owner", OW'(owner), OW'(2));
`endif
    check("err_sticky", OW'(protocol_err), OW'(1));
    advance();

    // Icache line fill at 0x100.
    do_reset();
    check("reset_clears_err", OW'(protocol_err), OW'(0));
    beat = 0; pulses = 0;
    mem_ready = 1;
    for (int c = 0; c < 10; c++) begin
      ic_ren = (c < 5);
      ic_addr = 32'h100 + 32'((c > 0) ? c - 1 : 0);
      drive_resp();
      sample("fill");
      if (c == 1) check("fill_owner", OW'(owner), OW'(1));
      if (ic_valid) begin
        check("fill_data", OW'(ic_rdata), OW'(32'hA000_0000 + 32'(pulses)));
        pulses++;
      end
      if (c == 7) check("fill_release", OW'(owner), OW'(0));
      advance();
    end
    check("fill_pulses", OW'(pulses), OW'(4));

    // Read throttle with memory withholding data.
    do_reset();
    ic_ren = 1; ic_addr = 32'h500; mem_ready = 1; acc = 0;
    for (int c = 0; c < 9; c++) begin
      mem_valid = (c == 6);
      mem_rdata = 32'h0000_0600;
      sample("throttle");
      if (ic_ready) acc++;
      if (c == 5) begin
        check("thr_full", OW'(acc), OW'(4));
        check("thr_ren", OW'(mem_ren), OW'(0));
        check("thr_ready", OW'(ic_ready), OW'(0));
      end
      if (c == 8) check("thr_one_more", OW'(acc), OW'(5));
      advance();
    end

    // Preemption: icache streams while dcache waits.
    do_reset();
    beat = 0; acc = 0; mem_ready = 1;
    for (int c = 0; c < 16; c++) begin
      ic_ren = (c < 10); ic_addr = 32'h700 + 32'(c);
      dc_ren = (c >= 1 && c < 14); dc_addr = 32'h600;
      drive_resp();
      sample("preempt");
      ow[c] = owner;
      if (ic_ready && ic_ren) acc++;
      advance();
    end
    check("pre_ic_accepts", OW'(acc), OW'(4));
    check("pre_hold", OW'(ow[6]), OW'(1));
    check("pre_idle", OW'(ow[7]), OW'(0));
    check("pre_dc", OW'(ow[8]), OW'(2));

    // Reset in the middle of a fill, then a stale beat.
    do_reset();
    ic_ren = 1; ic_addr = 32'h100; mem_ready = 1;
    for (int c = 0; c < 3; c++) begin
      sample("rst_fill");
      advance();
    end
    rst = 1;
    sample("rst_assert");
    advance();
    rst = 0; clear_inputs();
    mem_valid = 1; mem_rdata = 32'h0000_0BAD;
    sample("rst_after");
    check("rst_all_zero", dut_obs(), '0);
    advance();
    mem_valid = 0;
    sample("rst_stale");
    check("rst_stale_err", OW'(protocol_err), OW'(1));
    advance();

    // Random traffic against the model.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(599) == 0);
      ic_ren = ($urandom_range(3) != 0);
      ic_addr = $urandom;
      r = $urandom_range(3);
      dc_ren = (r == 1); dc_wen = (r == 2);
      dc_addr = $urandom; dc_wdata = $urandom;
      mem_ready = ($urandom_range(3) != 0);
      mem_valid = (m_q.size() > 0 && $urandom_range(2) != 0) || ($urandom_range(499) == 0);
      mem_rdata = $urandom;
      sample("random");
      advance();
    end
    rst = 0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
